cla_seq_divider: RTL and testbench
==================================

# cla_seq_divider

Sequential restoring divider that runs addition in reverse: it repeatedly subtracts the divisor, using a carry-lookahead subtract stage (a + ~b + 1), to produce quotient and remainder. It sits beside the 4-bit lookahead adder in the arithmetic library. It provides the inverse operation for datapaths that already use that adder, and is controlled by a start/done handshake.

## Interface
- WIDTH, 4, operand, quotient and remainder width; legal range 2..16
- clk  input  1  rising-edge clock
- rst  input  1  one clock; reset is synchronous and active-high
- start  input  1  request; sampled only when idle and not in reset
- dividend  input  WIDTH  unsigned dividend; captured on the accepted start
- divisor  input  WIDTH  unsigned divisor; captured on the accepted start
- busy  output  1  high from the cycle after an accepted start until done drops
- done  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid while it is high
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  set when the captured divisor was 0

## Operation
- FSM states: IDLE, CALC, DONE.
- Reset: state=IDLE. busy, done, quotient, remainder, div_by_zero and the iteration counter all clear to 0.
- **IDLE**
  - If start=1, capture the operands: D=divisor, Q=dividend, R=0, count=0.
  - If divisor≠0, go to CALC.
  - If divisor=0, go to DONE with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
- **CALC**, one iteration per cycle:
  - {R,Q} shifts left 1.
  - Trial T = {0,R_shifted} − {0,D}, computed as (WIDTH+1)-bit lookahead add of the one's complement with carry-in 1. Borrow = ~carry_out.
  - If borrow=0: R=T[WIDTH-1:0] and Q[0]=1. Otherwise R is kept and Q[0]=0.
  - count increments. After the WIDTH-th iteration (count==WIDTH-1), go to DONE.
- **DONE**
  - Drive quotient=Q, remainder=R and div_by_zero, with done=1 for exactly one cycle.
  - Return to IDLE.
- Outputs hold their last values in IDLE until the next accepted start. On that start, div_by_zero clears unless the new divisor is 0.
- start is ignored while busy=1, including during the DONE cycle. A new start can be accepted in the first IDLE cycle after done.
- Operand inputs may change freely after capture; they have no effect on a running division.
- rst=1 in any state, including together with start, forces the reset values on the next edge. No done pulse is produced for an aborted operation.
- Invariant on every non-zero-divisor result: quotient*divisor + remainder = dividend, and remainder < divisor.

## Timing
- Edge E0 is the edge at which start is accepted.
- busy=1 from E0+1 through the DONE cycle inclusive.
- Non-zero divisor: CALC occupies edges E1..E_WIDTH. done=1 in the cycle after edge E(WIDTH+1), so latency = WIDTH+1 cycles from start to done (5 for WIDTH=4). busy=0 from E(WIDTH+2).
- Zero divisor: done=1 in the cycle after E1, so latency = 1 cycle.
- Throughput: one division per WIDTH+2 cycles when start is held high continuously.
- The subtract path is purely combinational within one cycle. The only registered outputs are busy, done, quotient, remainder and div_by_zero.

## Test plan
- Reset, then 11/3 with WIDTH=4 -> done exactly 5 cycles after the start edge; quotient=3, remainder=2, div_by_zero=0; busy high for 5 cycles.
- Boundary operands, run back to back:
  - 15/1 -> quotient=15, remainder=0.
  - 5/7 -> quotient=0, remainder=5.
  - 0/9 -> quotient=0, remainder=0.
  - 15/15 -> quotient=1, remainder=0.
- 9/0 -> done 1 cycle after start; quotient=15, remainder=9, div_by_zero=1. A following 8/2 -> quotient=4, remainder=0, div_by_zero=0.
- Start 14/4 accepted, then pulse start with 3/1 and change both operand inputs during CALC -> second request ignored; result quotient=3, remainder=2; a single done pulse.
- Assert rst at the 2nd CALC cycle of 13/2 -> all outputs 0 and busy=0 the next cycle, no done pulse. A fresh 13/2 -> quotient=6, remainder=1.
- Exhaustive sweep of all 256 dividend/divisor pairs with start held high -> every result matches the reference model, one done per WIDTH+2 cycles.

Source files
------------

// File: rtl/cla_seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, trial subtraction
// done as a (WIDTH+1)-bit carry-lookahead add of the one's complement plus one.
`timescale 1ns/1ps
module cla_seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int N  = WIDTH + 1;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_reg;
  logic [WIDTH-1:0]  d_reg;
  logic [WIDTH-1:0]  q_reg;
  logic [WIDTH-1:0]  r_reg;
  logic [CW-1:0]     count_reg;

  logic [WIDTH-1:0]  r_shifted;
  logic [WIDTH-1:0]  q_shifted;
  logic [N-1:0]      op_a;
  logic [N-1:0]      op_b;
  logic [N-1:0]      gen;
  logic [N-1:0]      prop;
  logic [N:0]        carry;
  logic [WIDTH-1:0]  trial;
  logic              borrow;

  assign r_shifted = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
  assign q_shifted = {q_reg[WIDTH-2:0], 1'b0};
  assign op_a      = {1'b0, r_shifted};
  assign op_b      = ~{1'b0, d_reg};
  assign gen       = op_a & op_b;
  assign prop      = op_a ^ op_b;

  // Each carry is a flat generate/propagate sum of products back to carry-in = 1.
  always_comb begin
    logic p_acc;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      p_acc = 1'b1;
      for (int j = i; j >= 0; j--) begin
        carry[i+1] = carry[i+1] | (p_acc & gen[j]);
        p_acc      = p_acc & prop[j];
      end
      carry[i+1] = carry[i+1] | p_acc;
    end
  end

  assign trial  = prop[WIDTH-1:0] ^ carry[WIDTH-1:0];
  assign borrow = ~carry[N];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count_reg   <= '0;
      d_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            d_reg     <= divisor;
            count_reg <= '0;
            if (divisor != '0) begin
              q_reg       <= dividend;
              r_reg       <= '0;
              div_by_zero <= 1'b0;
              state_reg   <= CALC;
            end else begin
              q_reg       <= '1;
              r_reg       <= dividend;
              div_by_zero <= 1'b1;
              state_reg   <= DONE;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        CALC: begin
          r_reg     <= borrow ? r_shifted : trial;
          q_reg     <= {q_shifted[WIDTH-1:1], ~borrow};
          count_reg <= count_reg + CW'(1);
          if (count_reg == CW'(WIDTH - 1)) state_reg <= DONE;
        end
        DONE: begin
          quotient  <= q_reg;
          remainder <= r_reg;
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_divider.sv
// Directed and exhaustive checks of cla_seq_divider at WIDTH=4.
`timescale 1ns/1ps
module tb_cla_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  cla_seq_divider #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Issues one request from an idle/done cycle and waits (bounded) for done.
  // lat = edges after the accepting edge until done is seen.
  task automatic start_and_wait(input logic [3:0] a, input logic [3:0] b,
                                output int lat, output int busy_cycles,
                                output logic [3:0] q, output logic [3:0] r,
                                output logic dz);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    $display("op %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", a, b, q, r, dz, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dividend = 4'd5; divisor = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (quotient !== 4'd0) begin n_fail++; $display("FAIL reset_q: got %0d expected 0", quotient); end
    n_checks++; if (remainder !== 4'd0) begin n_fail++; $display("FAIL reset_r: got %0d expected 0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b expected 0", div_by_zero); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    $display("reset checked");
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [3:0] q, r;
    logic dz;
    start_and_wait(4'd11, 4'd3, lat, bc, q, r, dz);
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    n_checks++; if (bc != 5) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 5", bc); end
    n_checks++; if (q !== 4'd3) begin n_fail++; $display("FAIL basic_q: got %0d expected 3", q); end
    n_checks++; if (r !== 4'd2) begin n_fail++; $display("FAIL basic_r: got %0d expected 2", r); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b expected 0", dz); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 1", busy); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (quotient !== 4'd3 || remainder !== 4'd2) begin
      n_fail++; $display("FAIL basic_hold: got q=%0d r=%0d expected q=3 r=2", quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va [4] = '{4'd15, 4'd5, 4'd0, 4'd15};
    logic [3:0] vb [4] = '{4'd1,  4'd7, 4'd9, 4'd15};
    logic [3:0] eq [4] = '{4'd15, 4'd0, 4'd0, 4'd1};
    logic [3:0] er [4] = '{4'd0,  4'd5, 4'd0, 4'd0};
    int lat, bc;
    logic [3:0] q, r;
    logic dz;
    for (int i = 0; i < 4; i++) begin
      start_and_wait(va[i], vb[i], lat, bc, q, r, dz);
      n_checks++; if (lat != 5) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected 5", i, lat); end
      n_checks++; if (q !== eq[i] || r !== er[i]) begin
        n_fail++; $display("FAIL b2b_result[%0d]: got q=%0d r=%0d expected q=%0d r=%0d", i, q, r, eq[i], er[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_by_zero();
    int lat, bc;
    logic [3:0] q, r;
    logic dz;
    start_and_wait(4'd9, 4'd0, lat, bc, q, r, dz);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
    n_checks++; if (q !== 4'd15 || r !== 4'd9) begin
      n_fail++; $display("FAIL dbz_result: got q=%0d r=%0d expected q=15 r=9", q, r);
    end
    n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b expected 1", dz); end
    start_and_wait(4'd8, 4'd2, lat, bc, q, r, dz);
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL dbz_next_latency: got %0d expected 5", lat); end
    n_checks++; if (q !== 4'd4 || r !== 4'd0) begin
      n_fail++; $display("FAIL dbz_next_result: got q=%0d r=%0d expected q=4 r=0", q, r);
    end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL dbz_next_flag: got %b expected 0", dz); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start();
    int lat = 0;
    int dones = 0;
    dividend = 4'd14; divisor = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 1) begin start = 1'b1; dividend = 4'd3; divisor = 4'd1; end
      if (lat == 2) begin start = 1'b0; dividend = 4'd7; divisor = 4'd2; end
      if (lat == 4) begin start = 1'b1; dividend = 4'd3; divisor = 4'd1; end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    $display("op 14/4 with stray starts -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 5", lat); end
    n_checks++; if (quotient !== 4'd3 || remainder !== 4'd2) begin
      n_fail++; $display("FAIL ignore_result: got q=%0d r=%0d expected q=3 r=2", quotient, remainder);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL ignore_extra_done: got %0d expected 0", dones); end
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    int dones = 0;
    logic [3:0] q, r;
    logic dz;
    dividend = 4'd13; divisor = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("abort 13/2 -> busy=%b done=%b q=%0d r=%0d", busy, done, quotient, remainder);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_ctrl: got busy=%b done=%b expected 0 0", busy, done);
    end
    n_checks++; if (quotient !== 4'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: got q=%0d r=%0d dz=%b expected 0 0 0", quotient, remainder, div_by_zero);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL abort_done_seen: got %0d expected 0", dones); end
    start_and_wait(4'd13, 4'd2, lat, bc, q, r, dz);
    n_checks++; if (q !== 4'd6 || r !== 4'd1 || lat != 5) begin
      n_fail++; $display("FAIL abort_retry: got q=%0d r=%0d lat=%0d expected q=6 r=1 lat=5", q, r, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int idx = 0;
    int cycles = 0;
    int guard = 0;
    int a, b, exp_q, exp_r, exp_period;
    dividend = 4'd0; divisor = 4'd0; start = 1'b1;
    while (idx < 256 && guard < 2000) begin
      @(posedge clk); #1;
      cycles++;
      guard++;
      if (done === 1'b1) begin
        a = idx / 16;
        b = idx % 16;
        exp_q = (b == 0) ? 15 : a / b;
        exp_r = (b == 0) ? a : a % b;
        exp_period = (b == 0) ? 2 : 6;
        $display("sweep %0d/%0d -> q=%0d r=%0d dz=%0d after %0d cycles", a, b, quotient, remainder, div_by_zero, cycles);
        n_checks++; if (quotient !== 4'(exp_q) || remainder !== 4'(exp_r) || div_by_zero !== (b == 0)) begin
          n_fail++; $display("FAIL sweep_result %0d/%0d: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%0d",
                             a, b, quotient, remainder, div_by_zero, exp_q, exp_r, (b == 0));
        end
        if (idx > 0) begin
          n_checks++; if (cycles != exp_period) begin
            n_fail++; $display("FAIL sweep_period %0d/%0d: got %0d cycles expected %0d", a, b, cycles, exp_period);
          end
        end
        idx++;
        cycles = 0;
        if (idx < 256) begin
          dividend = 4'(idx / 16);
          divisor  = 4'(idx % 16);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_checks++; if (idx != 256) begin n_fail++; $display("FAIL sweep_timeout: got %0d results expected 256", idx); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_by_zero();
    test_ignored_start();
    test_reset_abort();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
